// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED blink sequencer: FSM states, register map
// and CTRL/STATUS bit positions.
// Optional feature macro used by the design: LED_SEQ_IRQ_EN.
package led_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STROBE = 3'd1,
        RUN    = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } led_seq_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_START  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_LEVEL = 2;

    // Data word written to the LED PIO for a given level.
    function automatic logic [31:0] strobe_data(input logic level);
        return {31'b0, level};
    endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Period down-counter for the LED blink sequencer.
// o_tc flags the cycle on which the running decrement lands on zero, so a
// load of N-1 followed by decrements spaces two strobes exactly N cycles apart.
module led_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count <= W'(1));

endmodule

// File: rtl/led_blink_sequencer.sv
// LED blink sequencer: Avalon-MM slave register file driving an LED PIO
// through a single-cycle master write strobe.
// Optional feature macro: LED_SEQ_IRQ_EN adds the irq output and CTRL.irq_en.
//
// state  | meaning
// IDLE   | no run active, master port idle
// STROBE | one-cycle write of the current level, counter reload
// RUN    | counting down to the next toggle
// STOP   | one-cycle write of 0 after a software abort
// DONE   | run finished, LED holds last level
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int COUNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

`ifdef LED_SEQ_IRQ_EN
    localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
    localparam logic [3:0] CTRL_WMASK = 4'h7;
`endif

    led_seq_state_t r_state;
    led_seq_state_t w_state_next;

    logic [3:0]          r_ctrl;
    logic [PERIOD_W-1:0] r_period;
    logic [COUNT_W-1:0]  r_count;
    logic [COUNT_W-1:0]  r_toggles;
    logic                r_level;
    logic                r_busy;
    logic                r_done;

    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_start;
    logic                w_stop;
    logic                w_toggle;
    logic                w_done_set;
    logic                w_done_clr;
    logic                w_tc;
    logic [PERIOD_W-1:0] w_period_eff;
    logic [31:0]         w_readdata;
    logic                w_unused_wdata;

    assign w_wr      = chipselect && !write_n;
    assign w_wr_ctrl = w_wr && (address == ADDR_CTRL);
    assign w_start   = w_wr_ctrl && writedata[CTRL_EN] && ((r_state == IDLE) || (r_state == DONE));
    assign w_stop    = w_wr_ctrl && !writedata[CTRL_EN] && ((r_state == STROBE) || (r_state == RUN));
    assign w_toggle  = (r_state == RUN) && !w_stop && w_tc;
    assign w_done_set = (r_state == STROBE) && (w_state_next == DONE);
    assign w_done_clr = w_wr && (address == ADDR_STATUS) && writedata[STAT_DONE];

    // Periods below 2 cannot fit a strobe plus a count cycle, so they act as 2.
    assign w_period_eff = (r_period < PERIOD_W'(2)) ? PERIOD_W'(2) : r_period;

    // Upper write-data bits are not stored for every register width.
    assign w_unused_wdata = ^writedata;

    led_seq_timer #(
        .W(PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (r_state == STROBE),
        .i_load_val (w_period_eff - PERIOD_W'(1)),
        .i_dec      (r_state == RUN),
        .o_tc       (w_tc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and master-port strobe generation.
    always_comb begin
        w_state_next = r_state;
        m_address    = 2'b00;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = 32'h0;
        case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_state_next = STROBE;
                end
            end
            STROBE: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = strobe_data(r_level);
                if (w_stop) begin
                    w_state_next = STOP;
                end else if (!r_ctrl[CTRL_MODE] ||
                             ((r_count != '0) && (r_toggles >= r_count))) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_stop) begin
                    w_state_next = STOP;
                end else if (w_tc) begin
                    w_state_next = STROBE;
                end
            end
            STOP: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = strobe_data(1'b0);
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl   <= '0;
            r_period <= '0;
            r_count  <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_CTRL:   r_ctrl   <= writedata[3:0] & CTRL_WMASK;
                ADDR_PERIOD: r_period <= writedata[PERIOD_W-1:0];
                ADDR_COUNT:  r_count  <= writedata[COUNT_W-1:0];
                default:     ;
            endcase
        end
    end

    // Run state: LED level, toggle tally, busy and done flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_level   <= 1'b0;
            r_toggles <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_start) begin
                r_level   <= writedata[CTRL_START];
                r_toggles <= '0;
            end else if (w_stop) begin
                r_level <= 1'b0;
            end else if (w_toggle) begin
                r_level   <= ~r_level;
                r_toggles <= r_toggles + COUNT_W'(1);
            end
            r_busy <= (w_state_next == STROBE) || (w_state_next == RUN) ||
                      (w_state_next == STOP);
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_start || w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    // Register read mux, unused bits read as zero.
    always_comb begin
        w_readdata = 32'h0;
        case (address)
            ADDR_CTRL:   w_readdata[3:0]          = r_ctrl;
            ADDR_PERIOD: w_readdata[PERIOD_W-1:0] = r_period;
            ADDR_COUNT:  w_readdata[COUNT_W-1:0]  = r_count;
            ADDR_STATUS: begin
                w_readdata[STAT_BUSY]  = r_busy;
                w_readdata[STAT_DONE]  = r_done;
                w_readdata[STAT_LEVEL] = r_level;
            end
            default:     w_readdata = 32'h0;
        endcase
    end

    assign readdata = w_readdata;

`ifdef LED_SEQ_IRQ_EN
    logic r_irq;

    // Interrupt follows done gated by irq_en, one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_done & r_ctrl[CTRL_IRQ_EN];
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench for led_blink_sequencer. Expected strobe times and
// data come from the blink rules: strobe k of a run started by a CTRL write
// in cycle t lands at t+1+k*P with level start^(k odd).
`timescale 1ns/1ps
module tb_led_blink_sequencer;

    localparam int PERIOD_W = 24;
    localparam int COUNT_W  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] data;
    } strobe_t;

    strobe_t strobes[$];

    led_blink_sequencer #(
        .PERIOD_W(PERIOD_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle with any master-bus activity.
    always @(negedge clk) begin
        if (m_chipselect === 1'b1 || m_write_n === 1'b0)
            strobes.push_back('{cyc, m_address, m_chipselect, m_write_n, m_writedata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d, output int t);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d; t = cyc;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        strobes.delete();
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected 0", a, rd);
            end
        end
        checks++;
        if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_address !== 2'd0 || m_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_master_idle: cs=%b wn=%b addr=%0d data=%h expected 0/1/0/0",
                     m_chipselect, m_write_n, m_address, m_writedata);
        end
        checks++;
        if (strobes.size() != 0) begin
            errors++;
            $display("FAIL reset_no_strobe: got %0d strobes expected 0", strobes.size());
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd, p, c, exp_ctrl;
        int t;
        for (int i = 0; i < 4; i++) begin
            p = $urandom;
            c = $urandom;
            cpu_write(2'd1, p, t);
            cpu_write(2'd2, c, t);
            cpu_read(2'd1, rd);
            checks++;
            if (rd !== (p & 32'h00FF_FFFF)) begin
                errors++;
                $display("FAIL period_readback: got %h expected %h", rd, p & 32'h00FF_FFFF);
            end
            cpu_read(2'd2, rd);
            checks++;
            if (rd !== (c & 32'h0000_FFFF)) begin
                errors++;
                $display("FAIL count_readback: got %h expected %h", rd, c & 32'h0000_FFFF);
            end
        end
        cpu_write(2'd0, 32'hFFFF_FFFA, t);
`ifdef LED_SEQ_IRQ_EN
        exp_ctrl = 32'hA;
`else
        exp_ctrl = 32'h2;
`endif
        cpu_read(2'd0, rd);
        checks++;
        if (rd !== exp_ctrl) begin
            errors++;
            $display("FAIL ctrl_readback: got %h expected %h", rd, exp_ctrl);
        end
        cpu_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_en0_no_start: status %h expected 0", rd);
        end
    endtask

    // One complete run (steady, or blink with nonzero COUNT) against the model.
    task automatic test_run(input int period, input int count, input logic start,
                            input logic blink, input int quiet, input string name);
        int t, peff, n, d, dummy;
        logic exp_level;
        cpu_write(2'd1, 32'(period), dummy);
        cpu_write(2'd2, 32'(count), dummy);
        @(posedge clk); #1;
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0;
        writedata = {28'b0, 1'b0, start, blink, 1'b1}; t = cyc;
        strobes.delete();
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; address = 2'd3;
        peff = (period < 2) ? 2 : period;
        n = blink ? count : 0;
        d = t + 2 + n * peff;
        exp_level = start ^ ((n % 2) == 1);
        while (cyc < d + quiet) begin
            @(negedge clk);
            if (cyc == d - 1) begin
                checks++;
                if (readdata[1:0] !== 2'b01) begin
                    errors++;
                    $display("FAIL %s busy_before_done: status[1:0]=%b expected 01", name, readdata[1:0]);
                end
            end
            if (cyc == d) begin
                checks++;
                if (readdata !== {29'b0, exp_level, 2'b10}) begin
                    errors++;
                    $display("FAIL %s done_status: got %h expected %h", name, readdata, {29'b0, exp_level, 2'b10});
                end
            end
        end
        checks++;
        if (strobes.size() != n + 1) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected %0d", name, strobes.size(), n + 1);
        end else begin
            for (int k = 0; k <= n; k++) begin
                checks++;
                if (strobes[k].cyc != t + 1 + k * peff || strobes[k].addr !== 2'd0 ||
                    strobes[k].cs !== 1'b1 || strobes[k].wn !== 1'b0 ||
                    strobes[k].data !== {31'b0, start ^ (k % 2 == 1)}) begin
                    errors++;
                    $display("FAIL %s strobe%0d: cycle %0d data %h addr %0d, expected cycle %0d data %h addr 0",
                             name, k, strobes[k].cyc - t, strobes[k].data, strobes[k].addr,
                             1 + k * peff, {31'b0, start ^ (k % 2 == 1)});
                end
            end
        end
    endtask

    task automatic test_stop();
        int t, s, peff, m, dummy, nexp;
        logic [31:0] rd;
        peff = $urandom_range(3, 5);
        m = $urandom_range(4, 25);
        cpu_write(2'd1, 32'(peff), dummy);
        cpu_write(2'd2, 32'h0, dummy);
        @(posedge clk); #1;
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h3; t = cyc;
        strobes.delete();
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        repeat (m) @(posedge clk);
        #1;
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h0; s = cyc;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL stop_status: got %h expected 0", readdata);
        end
        nexp = (s - (t + 1)) / peff + 2;
        checks++;
        if (strobes.size() != nexp) begin
            errors++;
            $display("FAIL stop_strobe_count: got %0d expected %0d", strobes.size(), nexp);
        end else begin
            for (int k = 0; k < nexp - 1; k++) begin
                checks++;
                if (strobes[k].cyc != t + 1 + k * peff || strobes[k].data !== 32'(k % 2)) begin
                    errors++;
                    $display("FAIL stop_run_strobe%0d: cycle %0d data %h expected cycle %0d data %h",
                             k, strobes[k].cyc - t, strobes[k].data, 1 + k * peff, 32'(k % 2));
                end
            end
            checks++;
            if (strobes[nexp-1].cyc != s + 1 || strobes[nexp-1].data !== 32'h0 ||
                strobes[nexp-1].cs !== 1'b1 || strobes[nexp-1].wn !== 1'b0) begin
                errors++;
                $display("FAIL stop_final_strobe: cycle s+%0d data %h expected s+1 data 0",
                         strobes[nexp-1].cyc - s, strobes[nexp-1].data);
            end
        end
        cpu_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL stop_ctrl: got %h expected 0", rd);
        end
    endtask

    task automatic test_done_clear();
        int t, d, dummy;
        cpu_write(2'd1, 32'd3, dummy);
        cpu_write(2'd2, 32'd1, dummy);
        @(posedge clk); #1;
        address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hF; t = cyc;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        d = t + 2 + 3;
        while (cyc < d - 1) begin
            @(posedge clk); #1;
        end
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        @(negedge clk);
        checks++;
        if (readdata[1] !== 1'b1) begin
            errors++;
            $display("FAIL done_set_priority: done=%b expected 1 (cycle offset %0d)", readdata[1], cyc - t);
        end
`ifdef LED_SEQ_IRQ_EN
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_high: got %b expected 1", irq);
        end
`endif
        cpu_write(2'd3, 32'h2, dummy);
        @(negedge clk);
        checks++;
        if (readdata[1] !== 1'b0) begin
            errors++;
            $display("FAIL done_clear: done=%b expected 0", readdata[1]);
        end
`ifdef LED_SEQ_IRQ_EN
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: got %b expected 0", irq);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        int dummy;
        logic [31:0] rd;
        cpu_write(2'd1, 32'($urandom_range(2, 4)), dummy);
        cpu_write(2'd2, 32'h0, dummy);
        cpu_write(2'd0, 32'h7, dummy);
        repeat ($urandom_range(3, 9)) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        strobes.delete();
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL midrun_reset_reg%0d: got %h expected 0", a, rd);
            end
        end
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++;
        if (strobes.size() != 0 || m_chipselect !== 1'b0 || m_write_n !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset_quiet: got %0d strobes cs=%b expected 0 strobes cs=0",
                     strobes.size(), m_chipselect);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_run(4, 3, 1'b1, 1'b1, 5, "blink_p4_c3");
        test_run($urandom_range(0, 6), $urandom_range(1, 4), 1'b1, 1'b0, 100, "steady");
        test_run(0, 2, 1'(($urandom_range(0, 1))), 1'b1, 5, "period0");
        for (int i = 0; i < 5; i++) begin
            test_run($urandom_range(0, 6), $urandom_range(1, 4), 1'(($urandom_range(0, 1))),
                     1'(($urandom_range(0, 1))), 6, "random");
        end
        test_stop();
        test_done_clear();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
